// File: rtl/data_sram_axi_bridge_if.sv
// AXI4 single-beat bus between the data SRAM bridge (master) and the system interconnect (slave).
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on AR, R, AW, W and B; resp fields are not carried.
// Ports: AR (araddr/arvalid/arready), R (rdata/rvalid/rready), AW (awaddr/awvalid/awready),
//        W (wdata/wstrb/wvalid/wready), B (bvalid/bready).
interface data_sram_axi_bridge_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/data_sram_axi_bridge.sv
// Converts each single-word data_sram request into one AXI4 single-beat read or write.
// Latency: 4 cycles minimum per access (IDLE, addr, data/resp, DONE); d_stall released in DONE.
// Backpressure: one transaction outstanding; d_stall holds the core until the AXI slave completes.
// Ports: clk, rst (async, active-low), data_sram_* request/response from the core,
//        d_stall back to the core, axi (master modport) towards the interconnect.
// Build option: define ADDR_TRANSLATE_EN to strip bits [31:29] of kseg0/kseg1 addresses.
module data_sram_axi_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              d_stall,
  data_sram_axi_bridge_if.master axi
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        state;
  logic              orphan;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;

  // Address translation is applied once, at latch time, so araddr/awaddr
  // stay stable for the whole transaction.
  function automatic logic [ADDR_W-1:0] xlate(input logic [ADDR_W-1:0] a);
`ifdef ADDR_TRANSLATE_EN
    logic [ADDR_W-1:0] r;
    r = a;
    if (a[31:30] == 2'b10) r[31:29] = 3'b000;
    return r;
`else
    return a;
`endif
  endfunction

  // An orphan DONE belongs to a request the core already abandoned, so it
  // must not release a new request that may be waiting.
  assign d_stall = data_sram_en & ~((state == S_DONE) & ~orphan);

  assign axi.araddr  = addr_q;
  assign axi.awaddr  = addr_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      orphan          <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      arvalid_q       <= 1'b0;
      rready_q        <= 1'b0;
      awvalid_q       <= 1'b0;
      wvalid_q        <= 1'b0;
      bready_q        <= 1'b0;
      data_sram_rdata <= '0;
    end else begin
      // Core dropped its request mid-flight: finish the bus transaction anyway.
      if (!data_sram_en && state != S_IDLE && state != S_DONE) orphan <= 1'b1;

      case (state)
        S_IDLE: begin
          if (data_sram_en) begin
            addr_q  <= xlate(data_sram_addr);
            wdata_q <= data_sram_wdata;
            wstrb_q <= data_sram_wen;
            if (data_sram_wen == 4'b0000) begin
              arvalid_q <= 1'b1;
              state     <= S_RD_ADDR;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= S_WR_REQ;
            end
          end
        end
        S_RD_ADDR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi.rvalid) begin
            rready_q        <= 1'b0;
            data_sram_rdata <= axi.rdata;
            state           <= S_DONE;
          end
        end
        S_WR_REQ: begin
          if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
          if (wvalid_q && axi.wready) wvalid_q <= 1'b0;
          // A channel counts as done if it already handshook or does so now.
          if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) begin
            bready_q <= 1'b1;
            state    <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          orphan <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed bench for data_sram_axi_bridge: reads, writes, slave stalls, flush,
// mid-transaction reset and optional address translation.
module tb_data_sram_axi_bridge;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_out;
  logic        d_stall;

  int checks;
  int errors;

  data_sram_axi_bridge_if #(.ADDR_W(32)) axi ();

  data_sram_axi_bridge #(.ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata_out),
    .d_stall         (d_stall),
    .axi             (axi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_xlate;
    checks = 0;
    errors = 0;
    rst = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
    axi.arready = 1'b0; axi.rdata = '0; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
    #2;
    chk("rst_arvalid", {31'b0, axi.arvalid}, 32'd0);
    chk("rst_rready",  {31'b0, axi.rready},  32'd0);
    chk("rst_awvalid", {31'b0, axi.awvalid}, 32'd0);
    chk("rst_wvalid",  {31'b0, axi.wvalid},  32'd0);
    chk("rst_bready",  {31'b0, axi.bready},  32'd0);
    chk("rst_araddr",  axi.araddr, 32'd0);
    chk("rst_wstrb",   {28'b0, axi.wstrb}, 32'd0);
    chk("rst_rdata",   rdata_out, 32'd0);
    chk("rst_stall",   {31'b0, d_stall}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // 1: zero-wait read of 0x1004
    @(negedge clk);
    axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = 32'hDEADBEEF;
    en = 1'b1; addr = 32'h0000_1004; wen = 4'h0;
    #1 chk("t1_idle_stall", {31'b0, d_stall}, 32'd1);
    chk("t1_idle_arvalid", {31'b0, axi.arvalid}, 32'd0);
    @(negedge clk); #1;
    chk("t1_arvalid", {31'b0, axi.arvalid}, 32'd1);
    chk("t1_araddr", axi.araddr, 32'h0000_1004);
    chk("t1_ar_stall", {31'b0, d_stall}, 32'd1);
    @(negedge clk); #1;
    chk("t1_rready", {31'b0, axi.rready}, 32'd1);
    chk("t1_r_stall", {31'b0, d_stall}, 32'd1);
    @(negedge clk); #1;
    chk("t1_done_stall", {31'b0, d_stall}, 32'd0);
    chk("t1_done_rdata", rdata_out, 32'hDEADBEEF);
    chk("t1_done_rready", {31'b0, axi.rready}, 32'd0);
    @(negedge clk);
    en = 1'b0; axi.arready = 1'b0; axi.rvalid = 1'b0;
    #1 chk("t1_idle_noen_stall", {31'b0, d_stall}, 32'd0);

    // 2: store, wready immediate, awready after 3 cycles of awvalid
    @(negedge clk);
    en = 1'b1; wen = 4'b0100; addr = 32'h10; wdata = 32'h00AB_0000;
    axi.wready = 1'b1; axi.awready = 1'b0;
    #1 chk("t2_idle_stall", {31'b0, d_stall}, 32'd1);
    @(negedge clk); #1;
    chk("t2_awvalid1", {31'b0, axi.awvalid}, 32'd1);
    chk("t2_wvalid1", {31'b0, axi.wvalid}, 32'd1);
    chk("t2_wstrb", {28'b0, axi.wstrb}, 32'h4);
    chk("t2_wdata", axi.wdata, 32'h00AB_0000);
    chk("t2_awaddr", axi.awaddr, 32'h10);
    @(negedge clk); #1;
    chk("t2_wvalid2", {31'b0, axi.wvalid}, 32'd0);
    chk("t2_awvalid2", {31'b0, axi.awvalid}, 32'd1);
    @(negedge clk); axi.awready = 1'b1;
    #1 chk("t2_awvalid3", {31'b0, axi.awvalid}, 32'd1);
    chk("t2_req_stall", {31'b0, d_stall}, 32'd1);
    @(negedge clk); axi.awready = 1'b0; axi.bvalid = 1'b1;
    #1 chk("t2_awvalid4", {31'b0, axi.awvalid}, 32'd0);
    chk("t2_bready", {31'b0, axi.bready}, 32'd1);
    chk("t2_resp_stall", {31'b0, d_stall}, 32'd1);
    @(negedge clk); #1;
    chk("t2_done_bready", {31'b0, axi.bready}, 32'd0);
    chk("t2_done_stall", {31'b0, d_stall}, 32'd0);
    chk("t2_rdata_kept", rdata_out, 32'hDEADBEEF);
    @(negedge clk); en = 1'b0; wen = 4'h0; axi.bvalid = 1'b0; axi.wready = 1'b0;

    // 3: read with rvalid delayed 5 cycles
    @(negedge clk);
    en = 1'b1; addr = 32'h2000; axi.arready = 1'b1; axi.rvalid = 1'b0; axi.rdata = 32'h55AA_55AA;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t3_wait_stall", {31'b0, d_stall}, 32'd1);
      chk("t3_wait_rdata", rdata_out, 32'hDEADBEEF);
    end
    @(negedge clk); axi.rvalid = 1'b1;
    #1 chk("t3_hs_stall", {31'b0, d_stall}, 32'd1);
    chk("t3_hs_rready", {31'b0, axi.rready}, 32'd1);
    @(negedge clk); #1;
    chk("t3_done_stall", {31'b0, d_stall}, 32'd0);
    chk("t3_done_rdata", rdata_out, 32'h55AA_55AA);
    @(negedge clk); en = 1'b0; axi.rvalid = 1'b0;

    // 4: flush in RD_DATA, new read of 0x20 presented the next cycle
    @(negedge clk);
    en = 1'b1; addr = 32'h30; axi.arready = 1'b1; axi.rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk); en = 1'b0;
    #1 chk("t4_flush_stall", {31'b0, d_stall}, 32'd0);
    @(negedge clk);
    en = 1'b1; addr = 32'h20; axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_F00D;
    #1 chk("t4_old_r_stall", {31'b0, d_stall}, 32'd1);
    @(negedge clk); axi.rvalid = 1'b0;
    #1 chk("t4_orphan_done_stall", {31'b0, d_stall}, 32'd1);
    @(negedge clk); #1;
    chk("t4_idle_stall", {31'b0, d_stall}, 32'd1);
    chk("t4_idle_arvalid", {31'b0, axi.arvalid}, 32'd0);
    @(negedge clk); axi.rvalid = 1'b1; axi.rdata = 32'h1234_5678;
    #1 chk("t4_arvalid", {31'b0, axi.arvalid}, 32'd1);
    chk("t4_araddr", axi.araddr, 32'h20);
    @(negedge clk); #1;
    chk("t4_r_stall", {31'b0, d_stall}, 32'd1);
    @(negedge clk); #1;
    chk("t4_done_stall", {31'b0, d_stall}, 32'd0);
    chk("t4_done_rdata", rdata_out, 32'h1234_5678);
    @(negedge clk); en = 1'b0; axi.rvalid = 1'b0;

    // 5: asynchronous reset while waiting in WR_RESP
    @(negedge clk);
    en = 1'b1; wen = 4'hF; addr = 32'h40; wdata = 32'hA5A5_A5A5;
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5_bready", {31'b0, axi.bready}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_bready", {31'b0, axi.bready}, 32'd0);
    chk("t5_rst_awvalid", {31'b0, axi.awvalid}, 32'd0);
    chk("t5_rst_wvalid", {31'b0, axi.wvalid}, 32'd0);
    chk("t5_rst_awaddr", axi.awaddr, 32'd0);
    chk("t5_rst_wstrb", {28'b0, axi.wstrb}, 32'd0);
    chk("t5_rst_rdata", rdata_out, 32'd0);
    en = 1'b0; wen = 4'h0; axi.awready = 1'b0; axi.wready = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    en = 1'b1; addr = 32'h50; axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = 32'h0BAD_F00D;
    #1 chk("t5_idle_arvalid", {31'b0, axi.arvalid}, 32'd0);
    @(negedge clk); #1;
    chk("t5_arvalid", {31'b0, axi.arvalid}, 32'd1);
    chk("t5_araddr", axi.araddr, 32'h50);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5_done_stall", {31'b0, d_stall}, 32'd0);
    chk("t5_done_rdata", rdata_out, 32'h0BAD_F00D);
    @(negedge clk); en = 1'b0;

    // 6: kseg1 address, translated only when the option is built in
`ifdef ADDR_TRANSLATE_EN
    exp_xlate = 32'h1FC0_0000;
`else
    exp_xlate = 32'hBFC0_0000;
`endif
    @(negedge clk);
    en = 1'b1; addr = 32'hBFC0_0000; axi.rdata = 32'h1122_3344;
    @(negedge clk); #1;
    chk("t6_araddr", axi.araddr, exp_xlate);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t6_done_rdata", rdata_out, 32'h1122_3344);
    @(negedge clk); en = 1'b0; axi.arready = 1'b0; axi.rvalid = 1'b0;

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_axi_bridge.md
Name: data_sram_axi_bridge

Overview:
Downstream consumer of the CPU wrapper's data SRAM port. Converts each single-word data_sram request into one AXI4 single-beat read or write transaction, and generates d_stall back to the core. Holds at most one outstanding transaction; sits between the CPU top and the system AXI interconnect.

Parameters:
ADDR_W, 32, width of the SRAM address and of araddr/awaddr.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
data_sram_en  in  1  request valid, held stable by the core while d_stall=1
data_sram_wen  in  4  byte write enables; 0 = read
data_sram_addr  in  ADDR_W  byte address
data_sram_wdata  in  32  store data, already byte-lane aligned
data_sram_rdata  out  32  registered load data
d_stall  out  1  core must hold the request this cycle
araddr  out  ADDR_W  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  ADDR_W  write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset (rst=0): state IDLE, orphan=0; arvalid, rready, awvalid, wvalid, bready = 0; addresses, wdata, wstrb, data_sram_rdata = 0. Takes effect immediately, including mid-transaction; the slave is reset with the bridge.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: on en=1 latch addr/wen/wdata. wen==0 -> RD_ADDR; otherwise -> WR_REQ. en=0 stays IDLE.
- RD_ADDR: arvalid=1 until arready; then -> RD_DATA.
- RD_DATA: rready=1; on rvalid, capture rdata into data_sram_rdata and go -> DONE.
- WR_REQ: awvalid and wvalid rise together; each drops independently on its own handshake. wstrb = latched wen. When both handshakes are complete (in the same or different cycles), go -> WR_RESP.
- WR_RESP: bready=1; on bvalid go -> DONE. bresp/rresp are ignored.
- DONE: one cycle, then IDLE. Requests are not sampled in DONE.
- d_stall = data_sram_en & ~(state==DONE & ~orphan). It is combinational and is 0 whenever en=0.
- Zero-wait slave read: stall high 3 cycles (IDLE, RD_ADDR, RD_DATA), DONE is the 4th cycle. Writes have the same 4-cycle minimum.
- data_sram_rdata holds its value until the next read completes. Writes do not change it.
- Flush: if en falls while state is not IDLE/DONE, set orphan=1. The AXI transaction still runs to completion. The orphan DONE does not release stall and goes to IDLE, clearing orphan. A new request presented meanwhile stays stalled and is issued from IDLE.
- Valid signals never drop before their handshake, and no address or data change occurs while valid is high.

Optional Feature:
ADDR_TRANSLATE_EN: when defined, addresses in 0x8000_0000-0xBFFF_FFFF (kseg0/kseg1) have bits [31:29] cleared on araddr/awaddr; all other addresses pass through. When not defined, araddr/awaddr equal the latched data_sram_addr.

Test Plan:
1. Read 0x0000_1004, zero-wait slave returning 0xDEADBEEF -> araddr=0x1004; d_stall high 3 cycles; data_sram_rdata=0xDEADBEEF in the DONE cycle, with d_stall=0.
2. Store wen=4'b0100, addr 0x10, wdata 0x00AB0000; wready immediate, awready delayed 3 cycles -> wstrb=0100; wvalid high 1 cycle; awvalid high 3 cycles; one bready handshake; then DONE.
3. Read with rvalid delayed 5 cycles -> d_stall stays high; rdata output keeps its old value until the handshake.
4. Flush: en drops in RD_DATA; next cycle a read of 0x20 (slave data 0x12345678) -> old R completes with no stall release; a second AR at 0x20 follows; rdata=0x12345678 on release.
5. rst=0 asserted in WR_RESP -> all valid/ready outputs go to 0 asynchronously; state IDLE; after release, a read proceeds normally.
6. Read 0xBFC0_0000 -> araddr=0x1FC0_0000 with ADDR_TRANSLATE_EN defined; 0xBFC0_0000 without it.
